// File: rtl/serial_mul_unit.sv
// SPI-slave shift-add multiplier: receives {op_b, op_a, opcode} LSB first,
// multiplies over Width cycles and shifts back one Width-bit result half.
module serial_mul_unit #(
  parameter int unsigned Width         = 8,
  parameter int unsigned NssPosition   = 0,
  parameter bit          SignedSupport = 1'b1,
  parameter int unsigned NssWidth      = NssPosition + 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NssWidth-1:0] spi_nss_i,
  input  logic                spi_mosi_i,
  output logic                spi_miso_o,
  output logic                o_busy
);

  localparam int unsigned PktW  = 2 * Width + 2;
  localparam int unsigned ProdW = 2 * Width;
  localparam int unsigned CntW  = $clog2(PktW);
  localparam int unsigned IdxW  = $clog2(Width);

  typedef enum logic [2:0] {
    S_IDLE, S_RECEIVING, S_COMPUTE, S_FIX, S_READY, S_SENDING
  } state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [PktW-2:0]     pkt_q;
  logic [1:0]          op_q;
  logic [ProdW-1:0]    mcand_q;
  logic [Width-1:0]    mplier_q;
  logic [ProdW-1:0]    acc_q;
  logic                neg_q;
  logic [Width-1:0]    result_q;
  logic                busy_q;

  logic                active_c;
  logic                miso_bit_c;
  logic                sgn_c;
  logic [Width-1:0]    a_w_c;
  logic [Width-1:0]    b_w_c;
  logic                a_neg_c;
  logic                b_neg_c;
  logic [Width-1:0]    a_mag_c;
  logic [Width-1:0]    b_mag_c;
  logic [ProdW-1:0]    prod_c;
  logic                nss_unused_c;

  assign active_c     = ~spi_nss_i[NssPosition];
  assign nss_unused_c = ^spi_nss_i;
  assign spi_miso_o   = active_c ? miso_bit_c : 1'bz;
  assign o_busy       = busy_q;

  always_comb begin
    miso_bit_c = 1'b0;
    case (state_q)
      S_READY:   miso_bit_c = 1'b1;
      S_SENDING: miso_bit_c = result_q[cnt_q[IdxW-1:0]];
      default:   miso_bit_c = 1'b0;
    endcase
  end

  // Operands at the last packet bit: op_b's MSB is still on mosi.
  always_comb begin
    sgn_c   = SignedSupport && (pkt_q[1:0] == 2'b10);
    a_w_c   = pkt_q[2 +: Width];
    b_w_c   = {spi_mosi_i, pkt_q[Width+2 +: Width-1]};
    a_neg_c = sgn_c & a_w_c[Width-1];
    b_neg_c = sgn_c & b_w_c[Width-1];
    a_mag_c = a_neg_c ? (~a_w_c + Width'(1)) : a_w_c;
    b_mag_c = b_neg_c ? (~b_w_c + Width'(1)) : b_w_c;
    prod_c  = neg_q ? (~acc_q + ProdW'(1)) : acc_q;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pkt_q    <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (active_c && spi_mosi_i && !miso_bit_c) state_q <= S_RECEIVING;
        end
        S_RECEIVING: begin
          if (!active_c) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pkt_q   <= '0;
          end else if (cnt_q == CntW'(PktW - 1)) begin
            cnt_q    <= '0;
            op_q     <= pkt_q[1:0];
            acc_q    <= '0;
            mcand_q  <= ProdW'(a_mag_c);
            mplier_q <= b_mag_c;
            neg_q    <= a_neg_c ^ b_neg_c;
            if (pkt_q[1:0] == 2'b11) begin
              result_q <= '1;
              state_q  <= S_READY;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_COMPUTE;
            end
          end else begin
            pkt_q[cnt_q] <= spi_mosi_i;
            cnt_q        <= cnt_q + CntW'(1);
          end
        end
        S_COMPUTE: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == CntW'(Width - 1)) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        S_FIX: begin
          result_q <= (op_q == 2'b00) ? prod_c[Width-1:0] : prod_c[ProdW-1:Width];
          busy_q   <= 1'b0;
          state_q  <= S_READY;
        end
        S_READY: begin
          if (active_c && !spi_mosi_i && miso_bit_c) begin
            cnt_q   <= '0;
            state_q <= S_SENDING;
          end
        end
        S_SENDING: begin
          if (!active_c || cnt_q == CntW'(Width - 1)) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mul_unit.sv
// Bench for serial_mul_unit: 8-bit signed and unsigned-only slaves on nss[0],
// a 12-bit slave on nss[1], all checked against an arithmetic reference model.
module tb_serial_mul_unit;

  logic       clk;
  logic       rst;
  logic [1:0] nss;
  logic       mosi;
  wire        miso8;
  wire        miso8u;
  wire        miso12;
  logic       busy8;
  logic       busy8u;
  logic       busy12;

  int checks;
  int failures;

  serial_mul_unit #(.Width(8), .NssPosition(0), .SignedSupport(1'b1), .NssWidth(2)) u_dut (
    .i_clock(clk), .i_reset(rst), .spi_nss_i(nss), .spi_mosi_i(mosi),
    .spi_miso_o(miso8), .o_busy(busy8));

  serial_mul_unit #(.Width(8), .NssPosition(0), .SignedSupport(1'b0), .NssWidth(2)) u_dut_u (
    .i_clock(clk), .i_reset(rst), .spi_nss_i(nss), .spi_mosi_i(mosi),
    .spi_miso_o(miso8u), .o_busy(busy8u));

  serial_mul_unit #(.Width(12), .NssPosition(1), .SignedSupport(1'b1), .NssWidth(2)) u_dut12 (
    .i_clock(clk), .i_reset(rst), .spi_nss_i(nss), .spi_mosi_i(mosi),
    .spi_miso_o(miso12), .o_busy(busy12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer product, then the requested half.
  function automatic logic [31:0] ref_result(input int w, input bit sgn_ok, input logic [1:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
    longint mask;
    longint sa;
    longint sb;
    longint p;
    mask = (longint'(1) << w) - 1;
    sa   = longint'(a) & mask;
    sb   = longint'(b) & mask;
    if (op == 2'b11) return 32'(mask);
    if (op == 2'b10 && sgn_ok) begin
      if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
    end
    p = sa * sb;
    if (op == 2'b00) return 32'(p & mask);
    return 32'((p >>> w) & mask);
  endfunction

  task automatic send_bits(input int sel, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int nbits);
    int          w;
    logic [31:0] msk;
    logic [63:0] pkt;
    w   = (sel == 0) ? 8 : 12;
    msk = (32'd1 << w) - 32'd1;
    pkt = 64'(op) | (64'(a & msk) << 2) | (64'(b & msk) << (w + 2));
    @(negedge clk);
    nss[sel] = 1'b0;
    mosi     = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      mosi = pkt[i];
    end
  endtask

  task automatic run_txn(input int sel, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit pause_nss, input int abort_at);
    int          w;
    int          lat;
    int          busy_n;
    int          exp_lat;
    bit          got;
    logic        m;
    logic        bz;
    logic [31:0] res;
    logic [31:0] res_u;
    logic [31:0] exp_s;
    logic [31:0] exp_u;
    logic [31:0] pmask;
    w      = (sel == 0) ? 8 : 12;
    exp_s  = ref_result(w, 1'b1, op, a, b);
    exp_u  = ref_result(w, 1'b0, op, a, b);
    send_bits(sel, op, a, b, 2 * w + 2);
    lat    = 0;
    busy_n = 0;
    got    = 1'b0;
    for (int k = 0; k < 4 * w; k++) begin
      @(negedge clk);
      mosi = 1'b1;
      bz   = (sel == 0) ? busy8 : busy12;
      m    = (sel == 0) ? miso8 : miso12;
      if (bz) busy_n++;
      if (nss[sel] == 1'b0 && m == 1'b1) begin
        got = 1'b1;
        break;
      end
      lat++;
      if (pause_nss && k == 2) nss[sel] = 1'b1;
      if (pause_nss && k == 5) nss[sel] = 1'b0;
    end
    if (!got) begin
      check_eq("ready_timeout", 64'(got), 64'(1));
      nss[sel] = 1'b1;
      mosi     = 1'b0;
      return;
    end
    exp_lat = (op == 2'b11) ? 0 : w + 1;
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("busy_cycles", 64'(busy_n), 64'(exp_lat));
    if (pause_nss) begin
      nss[sel] = 1'b1;
      repeat (3) @(negedge clk);
      nss[sel] = 1'b0;
      #1;
      m = (sel == 0) ? miso8 : miso12;
      check_eq("ready_hold", 64'(m), 64'(1));
    end
    mosi  = 1'b0;
    res   = '0;
    res_u = '0;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      res[i]   = (sel == 0) ? miso8 : miso12;
      res_u[i] = miso8u;
      if (i == abort_at) begin
        nss[sel] = 1'b1;
        pmask    = (32'd2 << i) - 32'd1;
        check_eq("abort_tx_bits", 64'(res & pmask), 64'(exp_s & pmask));
        @(negedge clk);
        check_eq("abort_tx_busy", 64'(busy8), 64'(0));
        return;
      end
    end
    @(negedge clk);
    m = (sel == 0) ? miso8 : miso12;
    check_eq("idle_miso", 64'(m), 64'(0));
    nss[sel] = 1'b1;
    check_eq("result", 64'(res), 64'(exp_s));
    if (sel == 0) check_eq("result_unsigned_inst", 64'(res_u), 64'(exp_u));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          sel;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          pause;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    nss      = 2'b11;
    mosi     = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy8", 64'(busy8), 64'(0));
    check_eq("rst_busy12", 64'(busy12), 64'(0));
    nss = 2'b00;
    #1;
    check_eq("rst_miso8", 64'(miso8), 64'(0));
    check_eq("rst_miso12", 64'(miso12), 64'(0));
    nss = 2'b11;
    @(negedge clk);
    rst = 1'b0;

    run_txn(0, 2'b00, 32'd13, 32'd11, 1'b0, -1);
    run_txn(0, 2'b01, 32'hFF, 32'hFF, 1'b0, -1);
    run_txn(0, 2'b10, 32'hFD, 32'h05, 1'b0, -1);
    run_txn(0, 2'b10, 32'h80, 32'h80, 1'b1, -1);
    run_txn(0, 2'b11, 32'h12, 32'h34, 1'b0, -1);
    run_txn(1, 2'b01, 32'hFFF, 32'h002, 1'b0, -1);
    run_txn(1, 2'b10, 32'h800, 32'h800, 1'b0, -1);
    run_txn(1, 2'b11, 32'h123, 32'h456, 1'b0, -1);

    // Abort mid-packet, then a clean transfer must be unaffected.
    send_bits(0, 2'b00, 32'h5A, 32'hA5, 7);
    @(negedge clk);
    nss[0] = 1'b1;
    mosi   = 1'b0;
    @(negedge clk);
    check_eq("abort_rx_busy", 64'(busy8), 64'(0));
    run_txn(0, 2'b00, 32'd2, 32'd3, 1'b0, -1);

    run_txn(0, 2'b00, 32'h37, 32'h29, 1'b0, 3);
    run_txn(0, 2'b01, 32'hC3, 32'h7E, 1'b0, -1);

    // Reset pulse while computing.
    send_bits(0, 2'b00, 32'h21, 32'h07, 18);
    repeat (4) @(negedge clk);
    check_eq("pre_rst_busy", 64'(busy8), 64'(1));
    rst = 1'b1;
    #1;
    check_eq("rst_mid_busy", 64'(busy8), 64'(0));
    check_eq("rst_mid_miso", 64'(miso8), 64'(0));
    @(negedge clk);
    rst  = 1'b0;
    nss  = 2'b11;
    mosi = 1'b0;
    run_txn(0, 2'b00, 32'h21, 32'h07, 1'b0, -1);

    for (int t = 0; t < 60; t++) begin
      sel   = int'($urandom_range(0, 1));
      op    = 2'($urandom_range(0, 3));
      a     = $urandom;
      b     = $urandom;
      if ($urandom_range(0, 4) == 0) a = (sel == 0) ? 32'h80 : 32'h800;
      if ($urandom_range(0, 4) == 0) b = (sel == 0) ? 32'hFF : 32'hFFF;
      pause = ($urandom_range(0, 3) == 0);
      run_txn(sel, op, a, b, pause, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
